// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side signal bundle for the hazard/stall unit.
// The master side is the pipeline (drives the ip_* fields); the slave side is the unit.
interface hazard_stall_unit_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic [4:0]           ip_IF_ID_RegisterRS1;
  logic [4:0]           ip_IF_ID_RegisterRS2;
  logic                 ip_IF_ID_UsesRS1;
  logic                 ip_IF_ID_UsesRS2;
  logic                 ip_IF_ID_Branch;
  logic                 ip_Jump;
  logic                 ip_BranchTaken;
  logic                 ip_ID_EX_RegWrite;
  logic                 ip_ID_EX_MemRead;
  logic [4:0]           ip_ID_EX_RegisterRD;
  logic                 ip_EX_MEM_MemRead;
  logic [4:0]           ip_EX_MEM_RegisterRD;
  logic                 ip_Hold;
  logic                 op_PCWrite;
  logic                 op_IF_ID_Write;
  logic                 op_ID_EX_Bubble;
  logic                 op_IF_ID_Flush;
  logic                 op_StallState;
  logic [CNT_WIDTH-1:0] op_StallCount;
  logic [CNT_WIDTH-1:0] op_FlushCount;

  modport master (
    output ip_IF_ID_RegisterRS1, ip_IF_ID_RegisterRS2, ip_IF_ID_UsesRS1, ip_IF_ID_UsesRS2,
           ip_IF_ID_Branch, ip_Jump, ip_BranchTaken, ip_ID_EX_RegWrite, ip_ID_EX_MemRead,
           ip_ID_EX_RegisterRD, ip_EX_MEM_MemRead, ip_EX_MEM_RegisterRD, ip_Hold,
    input  op_PCWrite, op_IF_ID_Write, op_ID_EX_Bubble, op_IF_ID_Flush, op_StallState,
           op_StallCount, op_FlushCount
  );

  modport slave (
    input  ip_IF_ID_RegisterRS1, ip_IF_ID_RegisterRS2, ip_IF_ID_UsesRS1, ip_IF_ID_UsesRS2,
           ip_IF_ID_Branch, ip_Jump, ip_BranchTaken, ip_ID_EX_RegWrite, ip_ID_EX_MemRead,
           ip_ID_EX_RegisterRD, ip_EX_MEM_MemRead, ip_EX_MEM_RegisterRD, ip_Hold,
    output op_PCWrite, op_IF_ID_Write, op_ID_EX_Bubble, op_IF_ID_Flush, op_StallState,
           op_StallCount, op_FlushCount
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Hazard detection / stall control for the 5-stage RV32I core.
// Stalls ID for dependencies forwarding cannot cover yet, flushes IF/ID on
// taken branches and jumps, and keeps saturating stall/flush counters.
module hazard_stall_unit #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic              ip_clk,
  input  logic              ip_rst_n,
  hazard_stall_unit_if.slave hz
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  logic [0:0]           state;
  logic [1:0]           remaining;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  logic                 ex_match;
  logic                 mem_match;
  logic [1:0]           stall_len;
  logic                 pc_write;
  logic                 if_id_write;
  logic                 bubble;
  logic                 flush;

  // Register-match detection against the EX and MEM destinations (x0 never matches)
  always_comb begin
    ex_match  = (hz.ip_ID_EX_RegisterRD != 5'd0) &&
                ((hz.ip_IF_ID_UsesRS1 && (hz.ip_ID_EX_RegisterRD == hz.ip_IF_ID_RegisterRS1)) ||
                 (hz.ip_IF_ID_UsesRS2 && (hz.ip_ID_EX_RegisterRD == hz.ip_IF_ID_RegisterRS2)));
    mem_match = (hz.ip_EX_MEM_RegisterRD != 5'd0) &&
                ((hz.ip_IF_ID_UsesRS1 && (hz.ip_EX_MEM_RegisterRD == hz.ip_IF_ID_RegisterRS1)) ||
                 (hz.ip_IF_ID_UsesRS2 && (hz.ip_EX_MEM_RegisterRD == hz.ip_IF_ID_RegisterRS2)));
  end

  // Stall length: the longest requirement among all applicable hazard rules
  always_comb begin
    stall_len = 2'd0;
    if (hz.ip_ID_EX_MemRead && hz.ip_ID_EX_RegWrite && ex_match)
      stall_len = 2'd1;
    if (hz.ip_IF_ID_Branch && hz.ip_ID_EX_RegWrite && !hz.ip_ID_EX_MemRead && ex_match)
      stall_len = 2'd1;
    if (hz.ip_IF_ID_Branch && hz.ip_EX_MEM_MemRead && mem_match)
      stall_len = 2'd1;
    if (hz.ip_IF_ID_Branch && hz.ip_ID_EX_MemRead && hz.ip_ID_EX_RegWrite && ex_match)
      stall_len = 2'd2;
  end

  // Pipeline control: reset forces a bubble, Hold freezes everything, a stall
  // (latched or newly detected) suppresses any flush
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    bubble      = 1'b0;
    flush       = 1'b0;
    if (!ip_rst_n) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      bubble      = 1'b1;
    end else if (hz.ip_Hold) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if ((state == STALL) || (stall_len != 2'd0)) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      bubble      = 1'b1;
    end else begin
      flush = (hz.ip_IF_ID_Branch && hz.ip_BranchTaken) || hz.ip_Jump;
    end
  end

  // Stall FSM: the first bubble is issued from IDLE, only the extra cycles are tracked
  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      state     <= IDLE;
      remaining <= 2'd0;
    end else if (!hz.ip_Hold) begin
      if (state == STALL) begin
        remaining <= remaining - 2'd1;
        if (remaining <= 2'd1)
          state <= IDLE;
      end else if (stall_len == 2'd2) begin
        state     <= STALL;
        remaining <= 2'd1;
      end
    end
  end

  // Saturating performance counters, frozen while Hold is high
  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!hz.ip_Hold) begin
      if (bubble && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.op_PCWrite      = pc_write;
  assign hz.op_IF_ID_Write  = if_id_write;
  assign hz.op_ID_EX_Bubble = bubble;
  assign hz.op_IF_ID_Flush  = flush;
  assign hz.op_StallState   = (state == STALL);
  assign hz.op_StallCount   = stall_cnt;
  assign hz.op_FlushCount   = flush_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed test-plan scenarios
// followed by randomized traffic, all checked against a rule-level model.
module tb_hazard_stall_unit;

  localparam int unsigned CW  = 4;
  localparam int          MAX = (1 << CW) - 1;

  logic ip_clk = 1'b0;
  logic ip_rst_n;
  int   errors = 0;
  int   checks = 0;

  // Reference model state: extra bubbles still owed, counter values
  int   pend;
  int   m_scnt;
  int   m_fcnt;

  hazard_stall_unit_if #(.CNT_WIDTH(CW)) hz ();

  hazard_stall_unit #(.CNT_WIDTH(CW)) dut (
    .ip_clk   (ip_clk),
    .ip_rst_n (ip_rst_n),
    .hz       (hz)
  );

  always #5 ip_clk = ~ip_clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit uses(input logic [4:0] rd);
    return (rd != 5'd0) &&
           ((hz.ip_IF_ID_UsesRS1 && rd == hz.ip_IF_ID_RegisterRS1) ||
            (hz.ip_IF_ID_UsesRS2 && rd == hz.ip_IF_ID_RegisterRS2));
  endfunction

  // Required stall length: maximum over the hazard rules
  function automatic int need();
    int n = 0;
    bit mex  = uses(hz.ip_ID_EX_RegisterRD);
    bit mmem = uses(hz.ip_EX_MEM_RegisterRD);
    bit br   = hz.ip_IF_ID_Branch;
    bit ld   = hz.ip_ID_EX_MemRead && hz.ip_ID_EX_RegWrite;
    if (ld && mex) n = (n > 1) ? n : 1;
    if (br && hz.ip_ID_EX_RegWrite && !hz.ip_ID_EX_MemRead && mex) n = (n > 1) ? n : 1;
    if (br && ld && mex) n = 2;
    if (br && hz.ip_EX_MEM_MemRead && mmem) n = (n > 1) ? n : 1;
    return n;
  endfunction

  task automatic clear_inputs();
    hz.ip_IF_ID_RegisterRS1 = 5'd0;
    hz.ip_IF_ID_RegisterRS2 = 5'd0;
    hz.ip_IF_ID_UsesRS1     = 1'b0;
    hz.ip_IF_ID_UsesRS2     = 1'b0;
    hz.ip_IF_ID_Branch      = 1'b0;
    hz.ip_Jump              = 1'b0;
    hz.ip_BranchTaken       = 1'b0;
    hz.ip_ID_EX_RegWrite    = 1'b0;
    hz.ip_ID_EX_MemRead     = 1'b0;
    hz.ip_ID_EX_RegisterRD  = 5'd0;
    hz.ip_EX_MEM_MemRead    = 1'b0;
    hz.ip_EX_MEM_RegisterRD = 5'd0;
    hz.ip_Hold              = 1'b0;
  endtask

  // One clock cycle: settle, compare all outputs against the model, advance model at the edge
  task automatic cycle();
    int e_pc, e_ifid, e_bub, e_fl, n;
    #1;
    if (!ip_rst_n) begin
      pend = 0; m_scnt = 0; m_fcnt = 0;
    end
    n = need();
    if (!ip_rst_n) begin
      e_pc = 0; e_ifid = 0; e_bub = 1; e_fl = 0;
    end else if (hz.ip_Hold) begin
      e_pc = 0; e_ifid = 0; e_bub = 0; e_fl = 0;
    end else if (pend > 0 || n > 0) begin
      e_pc = 0; e_ifid = 0; e_bub = 1; e_fl = 0;
    end else begin
      e_pc = 1; e_ifid = 1; e_bub = 0;
      e_fl = int'((hz.ip_IF_ID_Branch && hz.ip_BranchTaken) || hz.ip_Jump);
    end
    check("pcwrite",     int'(hz.op_PCWrite),      e_pc);
    check("if_id_write", int'(hz.op_IF_ID_Write),  e_ifid);
    check("bubble",      int'(hz.op_ID_EX_Bubble), e_bub);
    check("flush",       int'(hz.op_IF_ID_Flush),  e_fl);
    check("stall_state", int'(hz.op_StallState),   (ip_rst_n && pend > 0) ? 1 : 0);
    check("stall_count", int'(hz.op_StallCount),   m_scnt);
    check("flush_count", int'(hz.op_FlushCount),   m_fcnt);
    @(posedge ip_clk);
    if (ip_rst_n && !hz.ip_Hold) begin
      if (e_bub == 1 && m_scnt < MAX) m_scnt++;
      if (e_fl == 1 && m_fcnt < MAX) m_fcnt++;
      if (pend > 0) pend--;
      else if (n > 0) pend = n - 1;
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    ip_rst_n = 1'b0;
    cycle();
    ip_rst_n = 1'b1;
  endtask

  task automatic load_in_ex(input logic [4:0] rd);
    hz.ip_ID_EX_MemRead    = 1'b1;
    hz.ip_ID_EX_RegWrite   = 1'b1;
    hz.ip_ID_EX_RegisterRD = rd;
  endtask

  initial begin
    pend = 0; m_scnt = 0; m_fcnt = 0;
    clear_inputs();
    ip_rst_n = 1'b0;

    // Reset state
    cycle();
    check("reset_bubble", int'(hz.op_ID_EX_Bubble), 1);
    ip_rst_n = 1'b1;
    cycle();
    check("idle_pcwrite", int'(hz.op_PCWrite), 1);

    // Load-use: lw x5 in EX, add rs1=5 in ID -> one bubble
    load_in_ex(5'd5);
    hz.ip_IF_ID_RegisterRS1 = 5'd5; hz.ip_IF_ID_UsesRS1 = 1'b1;
    cycle();
    clear_inputs();
    cycle();
    check("loaduse_count", int'(hz.op_StallCount), 1);

    // Branch on EX load: two bubbles, StallState on the second, no flush
    do_reset();
    load_in_ex(5'd7);
    hz.ip_IF_ID_RegisterRS1 = 5'd7; hz.ip_IF_ID_UsesRS1 = 1'b1;
    hz.ip_IF_ID_RegisterRS2 = 5'd1; hz.ip_IF_ID_UsesRS2 = 1'b1;
    hz.ip_IF_ID_Branch = 1'b1; hz.ip_BranchTaken = 1'b1;
    cycle();
    check("brld_state2", int'(hz.op_StallState), 1);
    cycle();
    check("brld_count", int'(hz.op_StallCount), 2);
    check("brld_noflush", int'(hz.op_FlushCount), 0);
    clear_inputs();
    cycle();

    // x0 and unused-register filtering
    do_reset();
    load_in_ex(5'd0);
    hz.ip_IF_ID_UsesRS1 = 1'b1;
    cycle();
    load_in_ex(5'd9);
    hz.ip_IF_ID_RegisterRS2 = 5'd9; hz.ip_IF_ID_UsesRS2 = 1'b0;
    cycle();
    check("filter_count", int'(hz.op_StallCount), 0);

    // Taken branch and JAL each flush once
    do_reset();
    hz.ip_IF_ID_Branch = 1'b1; hz.ip_BranchTaken = 1'b1;
    cycle();
    check("flush_once", int'(hz.op_FlushCount), 1);
    clear_inputs();
    hz.ip_Jump = 1'b1;
    cycle();
    check("jal_flush", int'(hz.op_FlushCount), 2);

    // Jump with a stall: stall wins, flush re-evaluated afterwards
    do_reset();
    load_in_ex(5'd3);
    hz.ip_IF_ID_RegisterRS1 = 5'd3; hz.ip_IF_ID_UsesRS1 = 1'b1; hz.ip_Jump = 1'b1;
    cycle();
    clear_inputs(); hz.ip_Jump = 1'b1;
    cycle();
    check("jump_after_stall", int'(hz.op_FlushCount), 1);

    // Hold during the second cycle of an N=2 stall
    do_reset();
    load_in_ex(5'd7);
    hz.ip_IF_ID_RegisterRS1 = 5'd7; hz.ip_IF_ID_UsesRS1 = 1'b1; hz.ip_IF_ID_Branch = 1'b1;
    cycle();
    hz.ip_Hold = 1'b1;
    cycle();
    cycle();
    hz.ip_Hold = 1'b0;
    cycle();
    clear_inputs();
    cycle();
    check("hold_count", int'(hz.op_StallCount), 2);

    // Saturation: 20 load-use stalls
    do_reset();
    load_in_ex(5'd4);
    hz.ip_IF_ID_RegisterRS2 = 5'd4; hz.ip_IF_ID_UsesRS2 = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    clear_inputs();
    cycle();
    check("sat_count", int'(hz.op_StallCount), MAX);

    // Reset mid-STALL
    load_in_ex(5'd7);
    hz.ip_IF_ID_RegisterRS1 = 5'd7; hz.ip_IF_ID_UsesRS1 = 1'b1; hz.ip_IF_ID_Branch = 1'b1;
    cycle();
    ip_rst_n = 1'b0;
    #1;
    check("rst_mid_count", int'(hz.op_StallCount), 0);
    check("rst_mid_state", int'(hz.op_StallState), 0);
    check("rst_mid_bubble", int'(hz.op_ID_EX_Bubble), 1);
    cycle();
    ip_rst_n = 1'b1;
    clear_inputs();
    cycle();
    check("rst_release_count", int'(hz.op_StallCount), 0);

    // Randomized traffic over a small register set to provoke matches
    for (int i = 0; i < 600; i++) begin
      hz.ip_IF_ID_RegisterRS1 = 5'($urandom_range(0, 3));
      hz.ip_IF_ID_RegisterRS2 = 5'($urandom_range(0, 3));
      hz.ip_IF_ID_UsesRS1     = 1'($urandom);
      hz.ip_IF_ID_UsesRS2     = 1'($urandom);
      hz.ip_IF_ID_Branch      = 1'($urandom);
      hz.ip_Jump              = ($urandom_range(0, 3) == 0);
      hz.ip_BranchTaken       = 1'($urandom);
      hz.ip_ID_EX_RegWrite    = 1'($urandom);
      hz.ip_ID_EX_MemRead     = 1'($urandom);
      hz.ip_ID_EX_RegisterRD  = 5'($urandom_range(0, 3));
      hz.ip_EX_MEM_MemRead    = 1'($urandom);
      hz.ip_EX_MEM_RegisterRD = 5'($urandom_range(0, 3));
      hz.ip_Hold              = ($urandom_range(0, 7) == 0);
      ip_rst_n                = ($urandom_range(0, 59) != 0);
      cycle();
    end
    ip_rst_n = 1'b1;
    clear_inputs();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Hazard detection and pipeline-control block for the 5-stage RV32I core. It is the stall side of operand forwarding: it detects, in ID, dependencies that the forwarding paths to the ALU and to the ID-stage branch comparator cannot yet cover. For those it freezes PC and IF/ID and injects bubbles into ID/EX for a latched number of cycles. It also generates the IF/ID flush for taken branches and jumps, and keeps saturating stall and flush counters.

## Interface
- CNT_WIDTH, 16, width of each performance counter
- ip_clk  in  1  clock; all state updates on rising edge
- ip_rst_n  in  1  asynchronous, active-low reset
- ip_IF_ID_RegisterRS1  in  5  rs1 of instruction in ID
- ip_IF_ID_RegisterRS2  in  5  rs2 of instruction in ID
- ip_IF_ID_UsesRS1  in  1  ID instruction reads rs1
- ip_IF_ID_UsesRS2  in  1  ID instruction reads rs2
- ip_IF_ID_Branch  in  1  ID instruction is a branch or JALR, resolved in ID
- ip_Jump  in  1  ID instruction is JAL
- ip_BranchTaken  in  1  branch unit outcome for the ID instruction
- ip_ID_EX_RegWrite  in  1  EX instruction writes rd
- ip_ID_EX_MemRead  in  1  EX instruction is a load
- ip_ID_EX_RegisterRD  in  5  EX destination
- ip_EX_MEM_MemRead  in  1  MEM instruction is a load
- ip_EX_MEM_RegisterRD  in  5  MEM destination
- ip_Hold  in  1  external freeze (memory wait)
- op_PCWrite  out  1  PC update enable
- op_IF_ID_Write  out  1  IF/ID register enable
- op_ID_EX_Bubble  out  1  zero ID/EX control fields
- op_IF_ID_Flush  out  1  clear IF/ID to NOP
- op_StallState  out  1  0 = IDLE, 1 = STALL
- op_StallCount  out  CNT_WIDTH  bubble cycles issued
- op_FlushCount  out  CNT_WIDTH  flushes issued

## Operation
- **Match rule.** A match on rsX requires all of: UsesRSx = 1, RD = rsX, and RD ≠ 0.
- **Stall length N**, computed in IDLE as the maximum over all applicable rules; N = 0 if none apply:
  - Load-use: ID_EX_MemRead & ID_EX_RegWrite, with a match on either rs → 1
  - Branch on EX ALU result: Branch & ID_EX_RegWrite & !ID_EX_MemRead, with a match → 1
  - Branch on EX load: Branch & ID_EX_MemRead & ID_EX_RegWrite, with a match → 2
  - Branch on MEM load: Branch & EX_MEM_MemRead, with a match → 1
- **FSM**
  - IDLE, N = 0: PCWrite = 1, IF_ID_Write = 1, Bubble = 0. Flush = (Branch & BranchTaken) | Jump.
  - IDLE, N ≥ 1: this cycle is the first stall cycle. PCWrite = 0, IF_ID_Write = 0, Bubble = 1, Flush = 0. If N = 2, go to STALL with remaining = 1; otherwise stay in IDLE.
  - STALL: same stall outputs. Hazard inputs, BranchTaken and Jump are ignored. When remaining reaches 0, return to IDLE. The decision is latched; it is never recomputed mid-stall.
- **Hold.** When ip_Hold = 1: PCWrite = 0, IF_ID_Write = 0, Bubble = 0, Flush = 0. State, remaining count and both counters are frozen, and detection is suppressed. Hold has priority over everything except reset.
- **Counters**
  - StallCount increments on every cycle with Bubble = 1.
  - FlushCount increments on every cycle with Flush = 1.
  - Both saturate at 2^CNT_WIDTH − 1; no wrap-around.
- **Flush priority.** Flush is never asserted in a stall cycle; the branch outcome is invalid while operands are stale.

## Timing
- **Reset.** While ip_rst_n = 0, asynchronously: state = IDLE, remaining = 0, counters = 0. Outputs are forced to PCWrite = 0, IF_ID_Write = 0, Bubble = 1, Flush = 0, StallState = 0. After release, normal IDLE evaluation begins the same cycle.
- **Reset mid-stall.** The FSM aborts immediately to IDLE; no residual bubble after release.
- **Output paths.** Pipeline-control outputs are combinational from current state and inputs; zero-cycle latency in IDLE. StallState and the counters are registered.
- **Stall duration.** N = 2 produces exactly two consecutive bubble cycles. With Hold interleaved, the total is still exactly two bubble cycles.
- **Simultaneous events.** Jump together with a stall condition: stall wins, and the jump flush is re-evaluated once back in IDLE.

## Test plan
- **Load-use.** lw x5 in EX; add with rs1 = 5 in ID → one cycle of PCWrite = 0, Bubble = 1; then normal flow; StallCount = 1.
- **Branch on EX load.** lw x7 in EX; beq x7,x1 in ID → two consecutive bubble cycles, StallState = 1 on the second; StallCount = 2; no flush during the stall.
- **x0 and unused-register filtering.** ID_EX_RegisterRD = 0 with MemRead, or a match on rs2 with UsesRS2 = 0 → no stall.
- **Taken branch.** Branch = 1, BranchTaken = 1, no hazard → Flush = 1 for one cycle; FlushCount = 1. JAL gives the same result.
- **Hold during stall.** Hold = 1 in the cycle after an N = 2 detection → outputs frozen, Bubble = 0. After Hold drops, exactly one more bubble; StallCount = 2.
- **Saturation and reset.** With CNT_WIDTH = 4, 20 load-use stalls → StallCount = 15. Assert ip_rst_n = 0 mid-STALL → counters 0, Bubble = 1 during reset, then IDLE.
